flash_page_framer: RTL and testbench

//  Upstream feeder for the page-program burst writer. Collects a byte stream into a
//  one-page buffer and pads a short final page with PAD_BYTE. Pulses frame_flag to

---
 rtl/flash_page_framer.sv | 178 +++++++++++++++++
 tb/tb_flash_page_framer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_page_framer.sv
// flash_page_framer: buffers a byte stream into one flash page, pads a short page
// with PAD_BYTE, then announces the page with frame_flag and drains exactly
// PAGE_SIZE bytes over a valid/ready port to the page-program burst writer.
module flash_page_framer #(
  parameter int                 DSIZE     = 8,
  parameter int                 PAGE_SIZE = 256,
  parameter logic [DSIZE-1:0]   PAD_BYTE  = '1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_last,
  output logic             frame_flag,
  input  logic             wr_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [15:0]      page_count
);

  localparam int            AW       = $clog2(PAGE_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(PAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_ARM,
    S_DRAIN,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DSIZE-1:0]   out_data_q, out_data_d;
  logic               frame_flag_q, frame_flag_d;
  logic [15:0]        page_count_q, page_count_d;
  logic [1:0]         wait_cnt_q, wait_cnt_d;
  logic               seen_busy_q, seen_busy_d;

  logic               mem_we;
  logic [DSIZE-1:0]   mem_wdata;
  logic [DSIZE-1:0]   mem_q [PAGE_SIZE];

  // Pointer increment that wraps after the last page slot.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  // Next-state, datapath and handshake logic for the page framer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_flag_d = 1'b0;
    page_count_d = page_count_q;
    wait_cnt_d   = wait_cnt_q;
    seen_busy_d  = seen_busy_q;
    mem_we       = 1'b0;
    mem_wdata    = in_data;
    in_ready     = 1'b0;

    case (state_q)
      S_FILL: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          mem_we   = 1'b1;
          wr_ptr_d = ptr_next(wr_ptr_q);
          if (wr_ptr_q == LAST_IDX) begin
            state_d = S_ARM;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        mem_we    = 1'b1;
        mem_wdata = PAD_BYTE;
        wr_ptr_d  = ptr_next(wr_ptr_q);
        if (wr_ptr_q == LAST_IDX) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        if (!wr_busy) begin
          frame_flag_d = 1'b1;
          out_data_d   = mem_q[0];
          rd_ptr_d     = AW'(1);
          out_valid_d  = 1'b1;
          state_d      = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // rd_ptr starts at 1 after the first preload, so it only wraps back to
        // zero on the PAGE_SIZE-th accepted beat.
        if (out_valid_q && out_ready) begin
          out_data_d = mem_q[rd_ptr_q];
          rd_ptr_d   = ptr_next(rd_ptr_q);
          if (rd_ptr_q == '0) begin
            out_valid_d  = 1'b0;
            page_count_d = page_count_q + 16'd1;
            wait_cnt_d   = '0;
            seen_busy_d  = 1'b0;
            state_d      = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (seen_busy_q && !wr_busy) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = S_FILL;
        end else if (wr_busy) begin
          seen_busy_d = 1'b1;
        end else if (!seen_busy_q) begin
          if (wait_cnt_q == 2'd3) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = S_FILL;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_flag_q <= 1'b0;
      page_count_q <= '0;
      wait_cnt_q   <= '0;
      seen_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_flag_q <= frame_flag_d;
      page_count_q <= page_count_d;
      wait_cnt_q   <= wait_cnt_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  // Page buffer write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_flag = frame_flag_q;
  assign page_count = page_count_q;

endmodule

// File: tb/tb_flash_page_framer.sv
// Self-checking bench for flash_page_framer: drives byte transfers, models the
// expected padded pages with plain arrays, and scores the drained stream.
module tb_flash_page_framer;

  localparam int PAGE = 256;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  in_data = '0;
  logic        wr_busy = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        frame_flag;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] page_count;

  flash_page_framer #(
    .DSIZE(8),
    .PAGE_SIZE(PAGE),
    .PAD_BYTE(8'hFF)
  ) dut (
    .clock(clock),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .frame_flag(frame_flag),
    .wr_busy(wr_busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .page_count(page_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench controls and reference state
  bit          rdy_rand = 1'b0;
  bit          busy_auto = 1'b0;
  bit          busy_force = 1'b0;
  int          busy_left = 0;
  logic [7:0]  rx[$];
  logic [7:0]  expq[$];
  int          frames = 0;
  int          exp_frames = 0;
  logic [15:0] exp_count = '0;

  // Downstream ready: always ready, or a 50% coin flip each cycle.
  always begin
    @(posedge clock);
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Downstream burst writer busy: forced level, or busy for a random span after each frame.
  always begin
    @(posedge clock);
    #1;
    if (busy_auto) begin
      if (frame_flag && busy_left == 0) busy_left = $urandom_range(3, 600);
      if (busy_left > 0) begin
        wr_busy = 1'b1;
        busy_left--;
      end else begin
        wr_busy = 1'b0;
      end
    end else begin
      wr_busy = busy_force;
    end
  end

  // Output monitor: collects accepted beats and checks the valid/ready and frame rules.
  bit         prev_stall = 1'b0;
  bit         prev_ff = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clock) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_ff = 1'b0;
    end else begin
      if (frame_flag) begin
        chk("frame_single_pulse", 32'(prev_ff), 0);
        chk("frame_with_valid", 32'(out_valid), 1);
        frames++;
      end
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(out_valid), 1);
        chk("stall_data_hold", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) rx.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_ff = frame_flag;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit lst);
    int g;
    in_valid = 1'b1;
    in_data = d;
    in_last = lst;
    g = 0;
    while (!in_ready && g < 20000) begin
      @(negedge clock);
      g++;
    end
    if (g >= 20000) chk("in_ready_timeout", 0, 1);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Sends one transfer of n bytes and records the page the framer should emit.
  task automatic send_transfer(input int n, input int mode, input bit gaps, input bit last_on_full);
    logic [7:0] pg[PAGE];
    for (int i = 0; i < PAGE; i++) pg[i] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      bit lst;
      int g;
      case (mode)
        0:       d = 8'(i);
        1:       d = 8'(32'hA0 + i);
        default: d = 8'($urandom);
      endcase
      pg[i] = d;
      lst = (i == n - 1) && (n < PAGE || last_on_full);
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          in_valid = 1'b0;
          in_last = 1'($urandom_range(0, 1));
          in_data = 8'($urandom);
          @(negedge clock);
        end
      end
      send_byte(d, lst);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int i = 0; i < PAGE; i++) expq.push_back(pg[i]);
    exp_frames++;
    exp_count++;
  endtask

  task automatic measure_frame(output int lat);
    lat = 0;
    while (!frame_flag && lat < 5000) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Waits for a full drained page and compares it to the model.
  task automatic check_page(input string tag);
    int g;
    g = 0;
    while (rx.size() < PAGE && g < 30000) begin
      @(posedge clock);
      g++;
    end
    chk({tag, "_beats"}, rx.size(), PAGE);
    for (int i = 0; i < PAGE; i++) begin
      logic [7:0] e;
      e = expq.pop_front();
      if (rx.size() == 0) continue;
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx.pop_front()), 32'(e));
    end
    g = 0;
    while (!in_ready && g < 5000) begin
      @(negedge clock);
      g++;
    end
    chk({tag, "_back_to_fill"}, 32'(in_ready), 1);
    chk({tag, "_page_count"}, 32'(page_count), 32'(exp_count));
    chk({tag, "_frames"}, frames, exp_frames);
    chk({tag, "_no_extra_beats"}, rx.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int g;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_frame_flag", 32'(frame_flag), 0);
    chk("rst_page_count", 32'(page_count), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(negedge clock);

    // Full page 0x00..0xFF with in_last on the final byte: no padding
    send_transfer(PAGE, 0, 1'b0, 1'b1);
    measure_frame(lat);
    chk("full_page_latency", lat, 1);
    check_page("full");

    // Ten bytes then pad with 0xFF
    send_transfer(10, 1, 1'b0, 1'b0);
    measure_frame(lat);
    chk("short_page_latency", lat, 247);
    check_page("short");

    // Downstream busy for 20 cycles when the page is armed
    busy_force = 1'b1;
    send_transfer(PAGE, 2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("busy_in_ready", 32'(in_ready), 0);
      chk("busy_no_frame", 32'(frame_flag), 0);
      @(negedge clock);
    end
    busy_force = 1'b0;
    measure_frame(lat);
    chk("busy_release_latency", lat, 2);
    check_page("busy");

    // Reset in the middle of a drain
    send_transfer(PAGE, 2, 1'b0, 1'b0);
    g = 0;
    while (rx.size() < 100 && g < 5000) begin
      @(posedge clock);
      #2;
      g++;
    end
    chk("mid_drain_reached", 32'(rx.size() >= 100), 1);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_frame_flag", 32'(frame_flag), 0);
    chk("abort_page_count", 32'(page_count), 0);
    chk("abort_out_data", 32'(out_data), 0);
    chk("abort_in_ready_in_rst", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 32'(in_ready), 1);
    rx.delete();
    expq.delete();
    exp_count = '0;
    @(negedge clock);

    // Page counter wrap across three back-to-back pages
    force dut.page_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.page_count_q;
    exp_count = 16'hFFFE;
    for (int p = 0; p < 3; p++) begin
      send_transfer(PAGE, 2, 1'b0, 1'($urandom_range(0, 1)));
      check_page($sformatf("wrap%0d", p));
    end

    // Randomized traffic: 50% downstream ready, random busy spans, input gaps
    rdy_rand = 1'b1;
    busy_auto = 1'b1;
    for (int p = 0; p < 5; p++) begin
      int n;
      n = (p == 0 || $urandom_range(0, 1) == 1) ? PAGE : $urandom_range(1, PAGE - 1);
      send_transfer(n, 2, 1'b1, 1'($urandom_range(0, 1)));
      check_page($sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
